// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared definitions for the PLL reset/lock handshake block.
//               Holds the controller state encoding and the helpers used to
//               size its internal counters.
// Revision    : 1.0  initial release
// ============================================================================
package pll_ctrl_pkg;

  // Controller states. The encodings are fixed 3-bit values so they stay
  // stable across tools and are easy to spot in a waveform.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_t;

  // Counter width able to hold 'value'. The extra bit gives headroom, so a
  // count that ends exactly on a power of two still fits.
  function automatic int cnt_w(input int value);
    return $clog2(value) + 1;
  endfunction

  // Largest of three values, used to size one counter shared by all phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser. Both stages clear to 0 on an
//               asynchronous active-high reset.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               d    - asynchronous input  [WIDTH-1:0]
//               q    - synchronised output [WIDTH-1:0]
// Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // The first stage may go metastable. Only the second stage is consumed.
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_ctrl
// Description : Initiator side of the PLL reset/lock handshake. Pulses the
//               PLL reset and qualifies the synchronised lock flag. Retries
//               on lock timeout and gives up into FAULT after MAX_RETRY
//               consecutive timeouts. Counts lock losses and timeouts, and
//               holds the downstream system reset until lock has stayed
//               stable for STABLE_CYCLES cycles.
// Ports       : clkin1      - reference clock, same one that feeds the PLL
//               pll_rst     - asynchronous active-high block reset
//               pll_lock    - PLL lock flag, asynchronous to clkin1
//               relock_req  - single-cycle request to re-reset the PLL
//               fault_clr   - leave FAULT and restart the sequence
//               pll_rst_req - reset to the PLL, active high
//               sys_rst     - downstream reset, active high
//               locked_ok   - high only in LOCKED
//               fault       - high only in FAULT
//               relock_cnt  - lock-loss events, saturating [CNT_W-1:0]
//               timeout_cnt - lock timeouts, saturating     [CNT_W-1:0]
// Revision    : 1.0  initial release
// ============================================================================
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 20,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clkin1,
  input  logic             pll_rst,
  input  logic             pll_lock,
  input  logic             relock_req,
  input  logic             fault_clr,
  output logic             pll_rst_req,
  output logic             sys_rst,
  output logic             locked_ok,
  output logic             fault,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  // One cycle counter serves every timed phase. Only one phase runs at a
  // time, so the counter is sized for the longest of them.
  localparam int CYC_W   = cnt_w(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam int RETRY_W = cnt_w(MAX_RETRY);

  localparam logic [CYC_W-1:0]   RST_LAST    = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]   TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]   STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

  pll_state_t         state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   relock_d, timeout_d;
  logic               lock_s;

  // --------------------------------------------------------------------------
  // Lock flag synchroniser. Every FSM decision below uses lock_s only.
  // --------------------------------------------------------------------------
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clkin1),
    .rst (pll_rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // --------------------------------------------------------------------------
  // State, cycle counter, retry counter and event counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      state_q     <= ST_RESET;
      cyc_q       <= '0;
      retry_q     <= '0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      retry_q     <= retry_d;
      relock_cnt  <= relock_d;
      timeout_cnt <= timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    retry_d   = retry_q;
    relock_d  = relock_cnt;
    timeout_d = timeout_cnt;

    // A relock request overrides every other transition. It also restarts
    // the reset pulse when one is already in progress. It is not counted as
    // a loss or a timeout. FAULT ignores it and can only be left through
    // fault_clr.
    if (relock_req && (state_q != ST_FAULT)) begin
      state_d = ST_RESET;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (cyc_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout, so a lock that arrives in
          // the final cycle of the wait still counts as a lock.
          if (lock_s) begin
            state_d = ST_STABLE;
            cyc_d   = '0;
          end else if (cyc_q == TIMEOUT_LAST) begin
            cyc_d   = '0;
            retry_d = retry_q + 1'b1;
            if (timeout_cnt != '1) begin
              timeout_d = timeout_cnt + 1'b1;
            end
            state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RESET;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end

        ST_STABLE: begin
          // A dropout before qualification is a glitch, not a loss. The
          // wait restarts with a fresh timeout and no counter changes.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cyc_d   = '0;
          end else if (cyc_q == STABLE_LAST) begin
            state_d = ST_LOCKED;
            cyc_d   = '0;
            retry_d = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            cyc_d   = '0;
            if (relock_cnt != '1) begin
              relock_d = relock_cnt + 1'b1;
            end
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            state_d = ST_RESET;
            cyc_d   = '0;
            retry_d = '0;
          end
        end

        default: begin
          state_d = ST_RESET;
          cyc_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs. They are decoded from the next state, so each output
  // changes on the same edge that moves the FSM. sys_rst and locked_ok are
  // complements of one decode, so they always switch together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      pll_rst_req <= 1'b1;
      sys_rst     <= 1'b1;
      locked_ok   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pll_rst_req <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      sys_rst     <= (state_d != ST_LOCKED);
      locked_ok   <= (state_d == ST_LOCKED);
      fault       <= (state_d == ST_FAULT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_ctrl
// Description : Directed self-checking bench for pll_lock_ctrl with
//               RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8,
//               MAX_RETRY=3 and CNT_W=8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_lock_ctrl;

  localparam int B_REQ   = 0;
  localparam int B_SYS   = 1;
  localparam int B_LOCK  = 2;
  localparam int B_FAULT = 3;

  logic       clkin1 = 1'b0;
  logic       pll_rst;
  logic       pll_lock;
  logic       relock_req;
  logic       fault_clr;
  logic       pll_rst_req;
  logic       sys_rst;
  logic       locked_ok;
  logic       fault;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;

  logic [3:0] obs_bits;
  assign obs_bits = {fault, locked_ok, sys_rst, pll_rst_req};

  int   checks;
  int   errors;
  logic saw_req;

  always #5 clkin1 = ~clkin1;

  pll_lock_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (64),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (3),
    .CNT_W         (8)
  ) dut (
    .clkin1      (clkin1),
    .pll_rst     (pll_rst),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .fault_clr   (fault_clr),
    .pll_rst_req (pll_rst_req),
    .sys_rst     (sys_rst),
    .locked_ok   (locked_ok),
    .fault       (fault),
    .relock_cnt  (relock_cnt),
    .timeout_cnt (timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clkin1);
    #1;
    if (pll_rst_req === 1'b1) saw_req = 1'b1;
  endtask

  // Ticks until the selected output equals val. n is the number of ticks
  // taken, or -1 when the budget runs out.
  task automatic wait_bit(input int idx, input logic val, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (obs_bits[idx] === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    saw_req    = 1'b0;
    pll_rst    = 1'b1;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    fault_clr  = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_pll_rst_req", pll_rst_req, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_locked_ok", locked_ok, 0);
    chk("rst_fault", fault, 0);
    chk("rst_relock_cnt", relock_cnt, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);

    // 1. Nominal bring-up
    pll_rst = 1'b0;
    wait_bit(B_REQ, 1'b0, 50, n);
    chk("nom_pulse_len", n, 4);
    chk("nom_sys_rst_held", sys_rst, 1);
    repeat (10) tick();
    pll_lock = 1'b1;
    wait_bit(B_SYS, 1'b0, 100, n);
    chk("nom_release_lat", n, 11);
    chk("nom_locked_ok", locked_ok, 1);
    chk("nom_req_low", pll_rst_req, 0);
    chk("nom_relock_cnt", relock_cnt, 0);
    chk("nom_timeout_cnt", timeout_cnt, 0);

    // 4. Lock loss in LOCKED
    pll_lock = 1'b0;
    wait_bit(B_SYS, 1'b1, 20, n);
    chk("loss_sys_rst_lat", n, 3);
    chk("loss_locked_ok", locked_ok, 0);
    chk("loss_req_high", pll_rst_req, 1);
    chk("loss_relock_cnt", relock_cnt, 1);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("loss_pulse_len", n, 4);
    repeat (13) tick();
    pll_lock = 1'b1;
    wait_bit(B_LOCK, 1'b1, 100, n);
    chk("loss_relocked", locked_ok, 1);
    chk("loss_relock_cnt_kept", relock_cnt, 1);
    chk("loss_timeout_cnt", timeout_cnt, 0);

    // 5. relock_req from LOCKED, then a restart during RESET
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("rq_req_next", pll_rst_req, 1);
    chk("rq_sys_rst", sys_rst, 1);
    chk("rq_locked_ok", locked_ok, 0);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("rq_pulse_len", n, 4);
    wait_bit(B_LOCK, 1'b1, 100, n);
    chk("rq_relocked", locked_ok, 1);
    chk("rq_relock_cnt", relock_cnt, 1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("rq_restart_req", pll_rst_req, 1);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("rq_restart_len", n, 4);
    wait_bit(B_LOCK, 1'b1, 100, n);
    chk("rq_relocked2", locked_ok, 1);

    // 3. Glitch while in STABLE
    pll_lock   = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("gl_pulse_len", n, 4);
    saw_req = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_bit(B_SYS, 1'b0, 100, n);
    chk("gl_release_lat", n, 11);
    chk("gl_no_reset_pulse", saw_req, 0);
    chk("gl_relock_cnt", relock_cnt, 1);
    chk("gl_timeout_cnt", timeout_cnt, 0);

    // 2. Timeout retries into FAULT
    pll_lock   = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("to_pulse1_len", n, 4);
    wait_bit(B_REQ, 1'b1, 100, n);
    chk("to_wait1_len", n, 64);
    chk("to_timeout_cnt1", timeout_cnt, 1);
    chk("to_no_fault1", fault, 0);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("to_pulse2_len", n, 4);
    wait_bit(B_REQ, 1'b1, 100, n);
    chk("to_wait2_len", n, 64);
    chk("to_timeout_cnt2", timeout_cnt, 2);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("to_pulse3_len", n, 4);
    wait_bit(B_FAULT, 1'b1, 100, n);
    chk("to_wait3_len", n, 64);
    chk("to_fault_req", pll_rst_req, 1);
    chk("to_fault_sys_rst", sys_rst, 1);
    chk("to_timeout_cnt3", timeout_cnt, 3);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    repeat (5) tick();
    chk("to_fault_ignores_relock", fault, 1);
    chk("to_fault_req_held", pll_rst_req, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("to_clr_fault", fault, 0);
    chk("to_clr_req", pll_rst_req, 1);
    wait_bit(B_REQ, 1'b0, 20, n);
    chk("to_clr_pulse_len", n, 4);
    chk("to_counts_kept", timeout_cnt, 3);

    // 6. Asynchronous reset mid-STABLE
    pll_lock = 1'b1;
    repeat (5) tick();
    chk("ar_pre_req", pll_rst_req, 0);
    #3;
    pll_rst = 1'b1;
    #1;
    chk("ar_req_async", pll_rst_req, 1);
    chk("ar_sys_rst_async", sys_rst, 1);
    chk("ar_timeout_cnt", timeout_cnt, 0);
    chk("ar_relock_cnt", relock_cnt, 0);
    tick();
    tick();
    pll_rst = 1'b0;
    wait_bit(B_LOCK, 1'b1, 100, n);
    chk("ar_relocked", locked_ok, 1);
    chk("ar_relock_cnt_after", relock_cnt, 0);

    // Saturation of relock_cnt
    for (int i = 0; i < 255; i++) begin
      pll_lock = 1'b0;
      wait_bit(B_LOCK, 1'b0, 20, n);
      if (n < 0) break;
      pll_lock = 1'b1;
      wait_bit(B_LOCK, 1'b1, 100, n);
      if (n < 0) break;
    end
    chk("sat_reach_255", relock_cnt, 255);
    for (int i = 0; i < 5; i++) begin
      pll_lock = 1'b0;
      wait_bit(B_LOCK, 1'b0, 20, n);
      if (n < 0) break;
      pll_lock = 1'b1;
      wait_bit(B_LOCK, 1'b1, 100, n);
      if (n < 0) break;
    end
    chk("sat_hold_255", relock_cnt, 255);
    chk("sat_still_relocks", locked_ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
